// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: memory-miss, multi-cycle MUL,
// branch-redirect and load-use interlocks with a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_valid,
  input  logic [4:0]           d_rs1,
  input  logic [4:0]           d_rs2,
  input  logic                 d_uses_rs1,
  input  logic                 d_uses_rs2,
  input  logic                 de_valid,
  input  logic [4:0]           de_rd,
  input  logic                 de_is_load,
  input  logic                 de_is_mul,
  input  logic                 branch_taken,
  input  logic                 dcache_miss,
  input  logic                 dcache_ready,
  output logic                 fd_stall,
  output logic                 fd_flush,
  output logic                 de_stall,
  output logic                 de_valid_in,
  output logic                 em_stall,
  output logic                 em_valid_in,
  output logic                 mw_valid_in,
  output logic [1:0]           state,
  output logic [WORD_SIZE-1:0] stall_cycles
);

  localparam int unsigned CntW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MUL_LATENCY - 2);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMulWait = 2'd1,
    StMemWait = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   mul_pend_q, mul_pend_d;
  logic [WORD_SIZE-1:0]   stall_q, stall_d;

  logic wait_ready, mem_stall, eff_run, eff_mul;
  logic mul_issue, mul_hold, mul_release, br_flush, load_use, src_hit;

  // The cycle a miss resolves acts as RUN or MUL_WAIT, depending on whether a MUL was parked.
  assign wait_ready  = (state_q == StMemWait) && dcache_ready && !dcache_miss;
  assign mem_stall   = dcache_miss || ((state_q == StMemWait) && !dcache_ready);
  assign eff_mul     = !mem_stall && ((state_q == StMulWait) || (wait_ready && mul_pend_q));
  assign eff_run     = !mem_stall && ((state_q == StRun) || (wait_ready && !mul_pend_q));
  assign mul_issue   = eff_run && de_valid && de_is_mul;
  assign mul_hold    = eff_mul && (cnt_q != '0);
  assign mul_release = eff_mul && (cnt_q == '0);
  assign br_flush    = eff_run && !mul_issue && de_valid && branch_taken;
  assign src_hit     = (d_uses_rs1 && (d_rs1 == de_rd)) || (d_uses_rs2 && (d_rs2 == de_rd));
  assign load_use    = eff_run && !mul_issue && !br_flush && d_valid && de_valid &&
                       de_is_load && (de_rd != 5'd0) && src_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      mul_pend_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_pend_q <= mul_pend_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_pend_d = mul_pend_q;
    if (mem_stall) begin
      // MUL counter stays frozen for the whole memory stall.
      if (dcache_miss && !dcache_ready) begin
        if (state_q != StMemWait) mul_pend_d = (state_q == StMulWait);
        state_d = StMemWait;
      end else if ((state_q == StMemWait) && dcache_ready) begin
        state_d = mul_pend_q ? StMulWait : StRun;
      end
    end else if (mul_issue) begin
      cnt_d   = CntInit;
      state_d = StMulWait;
    end else if (mul_hold) begin
      cnt_d   = cnt_q - CntW'(1);
      state_d = StMulWait;
    end else begin
      state_d = StRun;
    end
    stall_d = (fd_stall && (stall_q != '1)) ? stall_q + WORD_SIZE'(1) : stall_q;
  end

  always_comb begin
    fd_stall    = 1'b0;
    fd_flush    = 1'b0;
    de_stall    = 1'b0;
    em_stall    = 1'b0;
    de_valid_in = d_valid;
    em_valid_in = de_valid;
    mw_valid_in = 1'b1;
    state       = state_q;
    if (!reset) begin
      fd_flush    = 1'b1;
      de_valid_in = 1'b0;
      em_valid_in = 1'b0;
      mw_valid_in = 1'b0;
      state       = StRun;
    end else if (mem_stall) begin
      fd_stall    = 1'b1;
      de_stall    = 1'b1;
      em_stall    = 1'b1;
      mw_valid_in = 1'b0;
    end else if (mul_issue || mul_hold) begin
      fd_stall    = 1'b1;
      de_stall    = 1'b1;
      em_valid_in = 1'b0;
    end else if (mul_release) begin
      em_valid_in = 1'b1;
    end else if (br_flush) begin
      fd_flush    = 1'b1;
      de_valid_in = 1'b0;
    end else if (load_use) begin
      fd_stall    = 1'b1;
      de_valid_in = 1'b0;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (WORD_SIZE=4 so saturation is reachable).
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       d_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       de_valid;
    logic [4:0] rd;
    logic       ld;
    logic       mul;
    logic       br;
    logic       miss;
    logic       rdy;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] out;
    logic [3:0] cnt;
  } exp_t;

  // exp bit order: fd_stall, fd_flush, de_stall, de_valid_in, em_stall, em_valid_in,
  // mw_valid_in, state[1:0]
  localparam logic [8:0] RstExp = 9'b010000000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic d_valid, d_uses_rs1, d_uses_rs2, de_valid, de_is_load, de_is_mul;
  logic branch_taken, dcache_miss, dcache_ready;
  logic [4:0] d_rs1, d_rs2, de_rd;
  logic fd_stall, fd_flush, de_stall, de_valid_in, em_stall, em_valid_in, mw_valid_in;
  logic [1:0] state;
  logic [3:0] stall_cycles;

  int total = 0;
  int bad = 0;
  logic [3:0] sc_model = 4'd0;
  exp_t sb[$];
  vec_t tbl[11];

  pipeline_hazard_ctrl #(.WORD_SIZE(4), .MUL_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2), .de_valid(de_valid), .de_rd(de_rd),
    .de_is_load(de_is_load), .de_is_mul(de_is_mul), .branch_taken(branch_taken),
    .dcache_miss(dcache_miss), .dcache_ready(dcache_ready), .fd_stall(fd_stall),
    .fd_flush(fd_flush), .de_stall(de_stall), .de_valid_in(de_valid_in), .em_stall(em_stall),
    .em_valid_in(em_valid_in), .mw_valid_in(mw_valid_in), .state(state),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2, input logic ev,
                               input logic [4:0] rd, input logic ld, input logic mul,
                               input logic br, input logic miss, input logic rdy);
    stim_t s;
    s = '{d_valid: dv, rs1: r1, rs2: r2, u1: u1, u2: u2, de_valid: ev, rd: rd, ld: ld,
          mul: mul, br: br, miss: miss, rdy: rdy};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    d_valid      = s.d_valid;
    d_rs1        = s.rs1;
    d_rs2        = s.rs2;
    d_uses_rs1   = s.u1;
    d_uses_rs2   = s.u2;
    de_valid     = s.de_valid;
    de_rd        = s.rd;
    de_is_load   = s.ld;
    de_is_mul    = s.mul;
    branch_taken = s.br;
    dcache_miss  = s.miss;
    dcache_ready = s.rdy;
  endtask

  task automatic check_out();
    exp_t e;
    logic [8:0] act;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries want >=1");
      return;
    end
    e = sb.pop_front();
    act = {fd_stall, fd_flush, de_stall, de_valid_in, em_stall, em_valid_in, mw_valid_in,
           state};
    total++;
    if (act !== e.out) begin
      bad++;
      $display("FAIL %s outputs: got %b want %b", e.name, act, e.out);
    end
    total++;
    if (stall_cycles !== e.cnt) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.cnt);
    end
  endtask

  task automatic step(input string name, input stim_t s, input logic [8:0] exp);
    @(posedge clk);
    #1;
    drive(s);
    sb.push_back('{name: name, out: exp, cnt: sc_model});
    if (exp[8] && sc_model != 4'hf) sc_model = sc_model + 4'd1;
    @(negedge clk);
    check_out();
  endtask

  task automatic apply_reset(input string name);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back('{name: name, out: RstExp, cnt: 4'd0});
    #1;
    check_out();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sc_model = 4'd0;
  endtask

  initial begin
    stim_t idle, mul_e, mul_miss, mul_rdy, mul_br, nxt, miss_s, rdy_s;
    idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mul_e    = mk(1, 1, 2, 1, 1, 1, 8, 0, 1, 0, 0, 0);
    mul_miss = mk(1, 1, 2, 1, 1, 1, 8, 0, 1, 0, 1, 0);
    mul_rdy  = mk(1, 1, 2, 1, 1, 1, 8, 0, 1, 0, 0, 1);
    mul_br   = mk(1, 1, 2, 1, 1, 1, 8, 0, 1, 1, 0, 0);
    nxt      = mk(1, 1, 2, 1, 1, 1, 8, 0, 0, 0, 0, 0);
    miss_s   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rdy_s    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    tbl[0]  = '{"idle",        mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 9'b000000100};
    tbl[1]  = '{"no_hazard",   mk(1, 6, 7, 1, 1, 1, 5, 1, 0, 0, 0, 0), 9'b000101100};
    tbl[2]  = '{"lu_rs1",      mk(1, 5, 7, 1, 1, 1, 5, 1, 0, 0, 0, 0), 9'b100001100};
    tbl[3]  = '{"lu_rs2",      mk(1, 3, 9, 1, 1, 1, 9, 1, 0, 0, 0, 0), 9'b100001100};
    tbl[4]  = '{"lu_unused",   mk(1, 5, 7, 0, 1, 1, 5, 1, 0, 0, 0, 0), 9'b000101100};
    tbl[5]  = '{"lu_x0",       mk(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0), 9'b000101100};
    tbl[6]  = '{"not_load",    mk(1, 5, 5, 1, 1, 1, 5, 0, 0, 0, 0, 0), 9'b000101100};
    tbl[7]  = '{"br_over_lu",  mk(1, 5, 7, 1, 1, 1, 5, 1, 0, 1, 0, 0), 9'b010001100};
    tbl[8]  = '{"br_no_valid", mk(1, 5, 7, 1, 1, 0, 5, 1, 0, 1, 0, 0), 9'b000100100};
    tbl[9]  = '{"miss_ready",  mk(1, 5, 7, 1, 1, 1, 5, 1, 0, 0, 1, 1), 9'b101111000};
    tbl[10] = '{"lu_no_dval",  mk(0, 5, 7, 1, 1, 1, 5, 1, 0, 0, 0, 0), 9'b000001100};

    drive(idle);
    #2;
    sb.push_back('{name: "reset_init", out: RstExp, cnt: 4'd0});
    check_out();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) step(tbl[i].name, tbl[i].s, tbl[i].exp);

    // Load-use: one bubble then normal flow, one stall counted.
    apply_reset("reset_lu");
    step("lu_stall", tbl[2].s, 9'b100001100);
    step("lu_after", tbl[1].s, 9'b000101100);

    // MUL alone: three stall cycles, release on the fourth.
    apply_reset("reset_mul");
    step("mul_t0", mul_e, 9'b101100100);
    step("mul_t1", mul_e, 9'b101100101);
    step("mul_t2", mul_e, 9'b101100101);
    step("mul_rel", mul_e, 9'b000101101);
    step("mul_after", nxt, 9'b000101100);

    // MUL with a miss starting in its second cycle.
    step("mm_t0", mul_e, 9'b101100100);
    step("mm_miss", mul_miss, 9'b101111001);
    step("mm_wait1", mul_e, 9'b101111010);
    step("mm_wait2", mul_e, 9'b101111010);
    step("mm_ready", mul_rdy, 9'b101100110);
    step("mm_t5", mul_e, 9'b101100101);
    step("mm_rel", mul_e, 9'b000101101);
    step("mm_after", nxt, 9'b000101100);

    // Branch during MUL_WAIT is ignored.
    step("mb_t0", mul_e, 9'b101100100);
    step("mb_br1", mul_br, 9'b101100101);
    step("mb_br2", mul_br, 9'b101100101);
    step("mb_rel", mul_br, 9'b000101101);
    step("mb_after", nxt, 9'b000101100);

    // Reset in the middle of a MUL.
    step("rm_t0", mul_e, 9'b101100100);
    apply_reset("reset_mid_mul");
    step("rm_after", nxt, 9'b000101100);

    // Saturation under a sustained miss.
    apply_reset("reset_sat");
    step("sat_first", miss_s, 9'b101010000);
    for (int i = 0; i < 18; i++) step("sat_hold", miss_s, 9'b101010010);
    step("sat_ready", rdy_s, 9'b000000110);
    step("sat_idle", idle, 9'b000000100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath word width; sets the stall_cycles counter width.
REQ-002 SHALL have parameter MUL_LATENCY, default 4, number of cycles a MUL occupies E; legal values >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port d_valid  input  1  valid instruction held in D.
REQ-006 SHALL have port d_rs1 / d_rs2  input  5 each  D-stage source register indices.
REQ-007 SHALL have port d_uses_rs1 / d_uses_rs2  input  1 each  the D-stage instruction reads that source.
REQ-008 SHALL have port de_valid  input  1  the instruction in E (D/E register output) is valid.
REQ-009 SHALL have port de_rd  input  5  E-stage destination register.
REQ-010 SHALL have port de_is_load / de_is_mul  input  1 each  the E-stage instruction is a load / MUL.
REQ-011 SHALL have port branch_taken  input  1  E resolved a taken branch; a redirect is required.
REQ-012 SHALL have port dcache_miss / dcache_ready  input  1 each  M-stage miss start / miss data returned.
REQ-013 SHALL have port fd_stall, fd_flush  output  1 each  F/D register hold / kill.
REQ-014 SHALL have port de_stall, de_valid_in  output  1 each  D/E register stall and valid inputs (de_valid_in=0 writes a bubble).
REQ-015 SHALL have port em_stall, em_valid_in, mw_valid_in  output  1 each  E/M register stall and valid inputs, and M/W register valid input.
REQ-016 SHALL have port state  output  2  FSM state: RUN=0, MUL_WAIT=1, MEM_WAIT=2.
REQ-017 SHALL have port stall_cycles  output  WORD_SIZE  performance counter of stall cycles.

Function
REQ-018 Default (no hazard): all stall and flush outputs 0; de_valid_in=d_valid, em_valid_in=de_valid, mw_valid_in=1.
REQ-019 Outputs SHALL be combinational from the current state and inputs; state, the MUL counter and stall_cycles are registered.
REQ-020 Priority per cycle, highest first: memory stall, MUL occupancy, branch redirect, load-use; lower-priority events are ignored that cycle and re-evaluated from held inputs.
REQ-021 Memory stall: dcache_miss=1 in any state, or state MEM_WAIT -> fd_stall=de_stall=em_stall=1 and mw_valid_in=0.
REQ-022 On dcache_miss=1 with dcache_ready=0, the next state SHALL be MEM_WAIT; the MUL counter freezes.
REQ-023 In MEM_WAIT with dcache_ready=1: no stall that cycle; next state MUL_WAIT if a MUL is pending, else RUN.
REQ-024 dcache_miss and dcache_ready both 1 in the same cycle SHALL cost exactly one stall cycle and no transition to MEM_WAIT.
REQ-025 MUL issue: in RUN with de_valid=1, de_is_mul=1 and no memory stall -> fd_stall=de_stall=1, em_valid_in=0, counter loaded with MUL_LATENCY-2, next state MUL_WAIT.
REQ-026 In MUL_WAIT with counter>0: same stall outputs as MUL issue; counter decrements by 1.
REQ-027 In MUL_WAIT with counter=0: release (no stalls, em_valid_in=1); next state RUN; the same MUL SHALL NOT be re-detected.
REQ-028 A MUL SHALL stall D and F for exactly MUL_LATENCY-1 cycles, plus any overlapping memory stall cycles.
REQ-029 branch_taken is honoured only in RUN with de_valid=1 -> fd_flush=1, de_valid_in=0; a branch_taken flush overrides the load-use rule.
REQ-030 Load-use: in RUN with d_valid=1, de_valid=1, de_is_load=1, de_rd!=0, and a used D source equal to de_rd -> fd_stall=1, de_valid_in=0 for exactly one cycle.
REQ-031 stall_cycles SHALL increment on each cycle with fd_stall=1 and saturate at all-ones.

Reset
REQ-032 While reset=0, outputs SHALL be forced asynchronously: fd_flush=1; fd_stall, de_stall, em_stall=0; de_valid_in, em_valid_in, mw_valid_in=0; state=RUN.
REQ-033 Reset SHALL clear the MUL counter and stall_cycles to 0, including during MUL_WAIT or MEM_WAIT.
REQ-034 After reset release, the first cycle SHALL behave as RUN under REQ-018.

Verification
REQ-035 Load-use test: load x5 in E, D add reading x5 -> one cycle with fd_stall=1, de_valid_in=0; next cycle default; stall_cycles=1.
REQ-036 MUL test: MUL_LATENCY=4, MUL in E at cycle T -> stalls at T..T+2, state 1,1,1 then 0, release at T+3, stall_cycles=3.
REQ-037 MUL with overlapping miss: dcache_miss at T+1, dcache_ready at T+4 -> stalls T..T+5 (6 cycles) and state returns MEM_WAIT->MUL_WAIT->RUN.
REQ-038 Simultaneous events: branch_taken with a load-use match -> fd_flush=1, fd_stall=0; branch_taken during MUL_WAIT -> ignored.
REQ-039 Reset mid-MUL: reset=0 at T+1 -> outputs per REQ-032 immediately; after release state=0 and stall_cycles=0.
REQ-040 Saturation test: stall_cycles forced near all-ones by sustained dcache_miss with WORD_SIZE=4 -> value holds at 15.
